// File: rtl/gate_pkg.sv
// Opcode encodings and the single-bit gate function shared by the gate pipeline.
// The function works on one bit lane; the top replicates it across the operand width.
package gate_pkg;

   localparam logic [2:0] OP_AND     = 3'd0;
   localparam logic [2:0] OP_OR      = 3'd1;
   localparam logic [2:0] OP_NAND    = 3'd2;
   localparam logic [2:0] OP_NOR     = 3'd3;
   localparam logic [2:0] OP_XOR     = 3'd4;
   localparam logic [2:0] OP_XNOR    = 3'd5;
   localparam logic [2:0] OP_NOT     = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   // Illegal opcode yields 0; the error flag is derived separately from the opcode.
   function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
      logic r;
      r = 1'b0;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         OP_NOT:  r = ~a;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// One elastic register slot (valid, result, error) of the gate pipeline.
// The slot loads whenever it is empty or its downstream neighbour takes its contents.
module gate_pipe_stage #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid_i,
   input  logic [WIDTH-1:0] up_y_i,
   input  logic             up_err_i,
   input  logic             down_ready_i,
   output logic             advance_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] y_o,
   output logic             err_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             err_q, err_d;

   assign advance_o = !valid_q || down_ready_i;

   // Payload only changes on a real load so the output stays stable while idle.
   always_comb begin
      valid_d = valid_q;
      y_d     = y_q;
      err_d   = err_q;
      if (advance_o) begin
         valid_d = up_valid_i;
         if (up_valid_i) begin
            y_d   = up_y_i;
            err_d = up_err_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   assign valid_o = valid_q;
   assign y_o     = y_q;
   assign err_o   = err_q;

endmodule

// File: rtl/param_gate_pipe.sv
// Pipelined bitwise gate unit: selectable gate applied per lane, results carried through
// STAGES elastic stages with valid/ready, plus all/any reduction flags on the output.
module param_gate_pipe
   import gate_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_all,
   output logic             y_any,
   output logic             op_err
);

   logic [WIDTH-1:0]              eval_y;
   logic                          eval_err;

   logic [STAGES-1:0]             stg_valid;
   logic [STAGES-1:0][WIDTH-1:0]  stg_y;
   logic [STAGES-1:0]             stg_err;
   logic [STAGES-1:0]             stg_adv;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign eval_y[i] = gate_eval(op, a[i], b[i]);
   end

   assign eval_err = (op == OP_ILLEGAL);

   // Ready ripples combinationally from the output back to stage 0.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_y;
      logic             up_err;
      logic             down_ready;

      if (k == 0) begin : g_head
         assign up_valid = in_valid;
         assign up_y     = eval_y;
         assign up_err   = eval_err;
      end else begin : g_body
         assign up_valid = stg_valid[k-1];
         assign up_y     = stg_y[k-1];
         assign up_err   = stg_err[k-1];
      end

      if (k == STAGES-1) begin : g_tail
         assign down_ready = out_ready;
      end else begin : g_mid
         assign down_ready = stg_adv[k+1];
      end

      gate_pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk          (clk),
         .rst          (rst),
         .up_valid_i   (up_valid),
         .up_y_i       (up_y),
         .up_err_i     (up_err),
         .down_ready_i (down_ready),
         .advance_o    (stg_adv[k]),
         .valid_o      (stg_valid[k]),
         .y_o          (stg_y[k]),
         .err_o        (stg_err[k])
      );
   end

   assign in_ready  = stg_adv[0];
   assign out_valid = stg_valid[STAGES-1];
   assign y         = stg_y[STAGES-1];
   assign op_err    = stg_err[STAGES-1];
   // Flags are forced low while no result is presented.
   assign y_all     = out_valid & (&y);
   assign y_any     = out_valid & (|y);

endmodule

// File: tb/tb_param_gate_pipe.sv
// Directed bench for param_gate_pipe at WIDTH=4, STAGES=2.
module tb_param_gate_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] y;
   logic       y_all;
   logic       y_any;
   logic       op_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   param_gate_pipe #(.WIDTH(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .y_all     (y_all),
      .y_any     (y_any),
      .op_err    (op_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = 4'h0; b = 4'h0;
      #2;
      n_checks++;
      if (out_valid !== 1'b0 || y !== 4'h0 || op_err !== 1'b0 || in_ready !== 1'b1 ||
          y_any !== 1'b0 || y_all !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: ov=%b y=%h err=%b ir=%b any=%b all=%b, want 0 0 0 1 0 0",
                  out_valid, y, op_err, in_ready, y_any, y_all);
      end
      tick();
      rst = 1'b0;
      // load one item and hold it at the output, then reset asynchronously mid-cycle
      in_valid = 1'b1; op = 3'd1; a = 4'hF; b = 4'h0;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_preload: ov=%b y=%h, want 1 f", out_valid, y);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || y !== 4'h0 || op_err !== 1'b0 || in_ready !== 1'b1 || y_all !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: ov=%b y=%h err=%b ir=%b all=%b, want 0 0 0 1 0",
                  out_valid, y, op_err, in_ready, y_all);
      end
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_nor();
      in_valid = 1'b1; op = 3'd3; a = 4'b0000; b = 4'b0101;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL nor_in_ready: got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL nor_early: out_valid=%b want 0 after one cycle", out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y !== 4'b1010 || y_any !== 1'b1 || y_all !== 1'b0 || op_err !== 1'b0) begin
         n_fail++;
         $display("FAIL nor_result: ov=%b y=%b any=%b all=%b err=%b, want 1 1010 1 0 0",
                  out_valid, y, y_any, y_all, op_err);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || y_any !== 1'b0 || y_all !== 1'b0) begin
         n_fail++;
         $display("FAIL nor_drain: ov=%b any=%b all=%b, want 0 0 0", out_valid, y_any, y_all);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_y [7];
      int got;
      int first_cyc;
      exp_y[0] = 4'b0001; exp_y[1] = 4'b0111; exp_y[2] = 4'b1110; exp_y[3] = 4'b1000;
      exp_y[4] = 4'b0110; exp_y[5] = 4'b1001; exp_y[6] = 4'b1100;
      got = 0;
      first_cyc = -1;
      out_ready = 1'b1;
      a = 4'b0011; b = 4'b0101;
      for (int c = 0; c < 16; c++) begin
         if (c < 7) begin
            in_valid = 1'b1;
            op = 3'(c);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid === 1'b1) begin
            if (first_cyc < 0) first_cyc = c + 1;
            n_checks++;
            if (got >= 7 || y !== exp_y[got] || op_err !== 1'b0) begin
               n_fail++;
               $display("FAIL truth_op%0d: y=%b err=%b, want %b 0", got, y,
                        op_err, (got < 7) ? exp_y[got] : 4'hx);
            end
            got++;
         end
      end
      n_checks++;
      if (got !== 7 || first_cyc !== 2) begin
         n_fail++;
         $display("FAIL truth_count: got %0d items first at cycle %0d, want 7 at 2", got, first_cyc);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd0; a = 4'hF; b = 4'h3;   // A -> 0011
      tick();
      op = 3'd1; a = 4'h8; b = 4'h1;                    // B -> 1001
      tick();
      op = 3'd4; a = 4'hF; b = 4'h5;                    // C -> 1010
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 4'b0011) begin
         n_fail++;
         $display("FAIL bp_full: ir=%b ov=%b y=%b, want 0 1 0011", in_ready, out_valid, y);
      end
      tick();
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || y !== 4'b0011 || y_all !== 1'b0 || y_any !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: ir=%b y=%b all=%b any=%b, want 0 0011 0 1", in_ready, y, y_all, y_any);
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || y !== 4'b1001) begin
         n_fail++;
         $display("FAIL bp_item_b: ov=%b y=%b, want 1 1001", out_valid, y);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y !== 4'b1010) begin
         n_fail++;
         $display("FAIL bp_item_c: ov=%b y=%b, want 1 1010", out_valid, y);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      in_valid = 1'b1; op = 3'd7; a = 4'hF; b = 4'hF;
      tick();
      op = 3'd0;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || y !== 4'h0 || op_err !== 1'b1 || y_any !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_op: ov=%b y=%h err=%b any=%b, want 1 0 1 0", out_valid, y, op_err, y_any);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y !== 4'hF || op_err !== 1'b0 || y_all !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_next: ov=%b y=%h err=%b all=%b, want 1 f 0 1", out_valid, y, op_err, y_all);
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      int seen;
      seen = 0;
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd1; a = 4'h3; b = 4'h4;
      tick();
      op = 3'd6; a = 4'h1;
      tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 4'h0) begin
         n_fail++;
         $display("FAIL flush_state: ov=%b ir=%b y=%h, want 0 1 0", out_valid, in_ready, y);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL flush_leak: %0d items emerged, want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_nor();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
